// File: rtl/qduc_sample_fifo.sv
// qduc_sample_fifo
//  Upstream feeder for the quadrature up-converter. Buffers signed I/Q sample
//  pairs arriving on a valid/ready handshake and releases one pair every RATIO
//  clocks. The release happens mid-period (UPDATE_PHASE), so the registered
//  out_i/out_q words stay stable around the up-converter's divided sample edge.
//
// Ports
//  clk, reset      system clock; synchronous active-high reset
//  s_valid/s_ready input pair handshake
//  s_i, s_q        input pair (signed, ISZ bits each)
//  enable          1: stream from FIFO, 0: output zeros without popping
//  out_i, out_q    registered output pair (signed)
//  out_strobe      one-cycle pulse after every output register update
//  level           pairs currently stored (0..DEPTH)
//  underflow       sticky flag: an update was due while enabled and empty
//  underflow_clr   clears underflow (a simultaneous new underflow wins)
module qduc_sample_fifo #(
  parameter int ISZ            = 16,
  parameter int DEPTH          = 16,
  parameter int RATIO          = 32,
  parameter int UPDATE_PHASE   = 15,
  parameter int UNDERFLOW_ZERO = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [ISZ-1:0]           s_i,
  input  logic [ISZ-1:0]           s_q,
  input  logic                     enable,
  output logic signed [ISZ-1:0]    out_i,
  output logic signed [ISZ-1:0]    out_q,
  output logic                     out_strobe,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     underflow,
  input  logic                     underflow_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(RATIO - 1);
  localparam logic [PW-1:0] PHASE_UPD  = PW'(UPDATE_PHASE);
  localparam logic [AW:0]   LEVEL_FULL = (AW + 1)'(DEPTH);

  logic [PW-1:0]      phase;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [2*ISZ-1:0]   mem [DEPTH];
  logic [2*ISZ-1:0]   head;
  logic               update_edge;
  logic               empty;
  logic               push;
  logic               pop;
  logic               starve;

  assign s_ready     = (level != LEVEL_FULL);
  assign empty       = (level == '0);
  assign update_edge = (phase == PHASE_UPD);
  assign push        = s_valid && s_ready;
  // A pair pushed on the update edge itself is not visible to that update:
  // 'empty' comes from the registered level, so there is no fall-through.
  assign pop         = update_edge && enable && !empty;
  assign starve      = update_edge && enable && empty;
  assign head        = mem[rd_ptr];

  // Free-running phase counter; shares reset with the up-converter divider so
  // the update instant keeps a fixed offset from its sample edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase <= '0;
    end else if (phase == PHASE_LAST) begin
      phase <= '0;
    end else begin
      phase <= phase + 1'b1;
    end
  end

  // Storage array is not reset; flushing is done by clearing pointers/level.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem[wr_ptr] <= {s_i, s_q};
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Output register: only touched on the update edge, strobe follows it.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_i      <= '0;
      out_q      <= '0;
      out_strobe <= 1'b0;
    end else begin
      out_strobe <= update_edge;
      if (update_edge) begin
        if (!enable) begin
          out_i <= '0;
          out_q <= '0;
        end else if (!empty) begin
          {out_i, out_q} <= head;
        end else if (UNDERFLOW_ZERO != 0) begin
          out_i <= '0;
          out_q <= '0;
        end
      end
    end
  end

  // Sticky underflow; setting takes priority over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      underflow <= 1'b0;
    end else if (starve) begin
      underflow <= 1'b1;
    end else if (underflow_clr) begin
      underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_qduc_sample_fifo.sv
// Directed testbench for qduc_sample_fifo. A second instance built with
// UNDERFLOW_ZERO=0 covers the hold-last-pair behaviour on underflow.
module tb_qduc_sample_fifo;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               s_valid = 1'b0;
  logic               s_ready;
  logic [15:0]        s_i = '0;
  logic [15:0]        s_q = '0;
  logic               enable = 1'b0;
  logic signed [15:0] out_i;
  logic signed [15:0] out_q;
  logic               out_strobe;
  logic [4:0]         level;
  logic               underflow;
  logic               underflow_clr = 1'b0;

  logic               h_s_valid = 1'b0;
  logic               h_s_ready;
  logic [15:0]        h_s_i = '0;
  logic [15:0]        h_s_q = '0;
  logic               h_enable = 1'b0;
  logic signed [15:0] h_out_i;
  logic signed [15:0] h_out_q;
  logic               h_out_strobe;
  logic [4:0]         h_level;
  logic               h_underflow;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  qduc_sample_fifo dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
    .s_i(s_i), .s_q(s_q), .enable(enable), .out_i(out_i), .out_q(out_q),
    .out_strobe(out_strobe), .level(level), .underflow(underflow),
    .underflow_clr(underflow_clr)
  );

  qduc_sample_fifo #(.UNDERFLOW_ZERO(0)) dut_hold (
    .clk(clk), .reset(reset), .s_valid(h_s_valid), .s_ready(h_s_ready),
    .s_i(h_s_i), .s_q(h_s_q), .enable(h_enable), .out_i(h_out_i),
    .out_q(h_out_q), .out_strobe(h_out_strobe), .level(h_level),
    .underflow(h_underflow), .underflow_clr(1'b0)
  );

  // Advance n clocks; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  // Advance to the cycle right after the update edge (cyc mod 32 == 16).
  task automatic to_update();
    do step(1); while (cyc % 32 != 16);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (out_i !== 16'sd0 || out_q !== 16'sd0) begin
      $display("[TB] FAIL reset_out: got %0d,%0d expected 0,0", out_i, out_q); miscompares++;
    end
    vectors++;
    if (s_ready !== 1'b1 || level !== 5'd0) begin
      $display("[TB] FAIL reset_fifo: got ready=%0b level=%0d expected ready=1 level=0", s_ready, level); miscompares++;
    end
    vectors++;
    if (out_strobe !== 1'b0 || underflow !== 1'b0) begin
      $display("[TB] FAIL reset_flags: got strobe=%0b uf=%0b expected 0,0", out_strobe, underflow); miscompares++;
    end
  endtask

  task automatic test_idle_underflow();
    $display("[TB] idle stream with empty FIFO");
    do_reset();
    enable = 1'b1;
    step(15);
    vectors++;
    if (out_strobe !== 1'b0 || underflow !== 1'b0) begin
      $display("[TB] FAIL pre_update: got strobe=%0b uf=%0b expected 0,0", out_strobe, underflow); miscompares++;
    end
    step(1);
    vectors++;
    if (out_strobe !== 1'b1 || underflow !== 1'b1 || out_i !== 16'sd0) begin
      $display("[TB] FAIL first_update: got strobe=%0b uf=%0b out_i=%0d expected 1,1,0", out_strobe, underflow, out_i); miscompares++;
    end
    step(1);
    vectors++;
    if (out_strobe !== 1'b0) begin
      $display("[TB] FAIL strobe_width: got %0b expected 0", out_strobe); miscompares++;
    end
    step(30);
    vectors++;
    if (out_strobe !== 1'b0) begin
      $display("[TB] FAIL strobe_early: got %0b expected 0 at cycle 47", out_strobe); miscompares++;
    end
    step(1);
    vectors++;
    if (out_strobe !== 1'b1) begin
      $display("[TB] FAIL strobe_period: got %0b expected 1 at cycle 48", out_strobe); miscompares++;
    end
  endtask

  task automatic test_stream();
    $display("[TB] two pairs streamed");
    do_reset();
    enable = 1'b1;
    s_valid = 1'b1; s_i = 16'd100; s_q = 16'(-100);
    step(1);
    s_i = 16'd200; s_q = 16'(-200);
    step(1);
    s_valid = 1'b0;
    vectors++;
    if (level !== 5'd2) begin
      $display("[TB] FAIL stream_level2: got %0d expected 2", level); miscompares++;
    end
    to_update();
    vectors++;
    if (out_i !== 16'sd100 || out_q !== -16'sd100 || level !== 5'd1) begin
      $display("[TB] FAIL stream_pair1: got %0d,%0d level=%0d expected 100,-100 level=1", out_i, out_q, level); miscompares++;
    end
    step(31);
    vectors++;
    if (out_i !== 16'sd100 || out_q !== -16'sd100) begin
      $display("[TB] FAIL stream_hold1: got %0d,%0d expected 100,-100", out_i, out_q); miscompares++;
    end
    step(1);
    vectors++;
    if (out_i !== 16'sd200 || out_q !== -16'sd200 || level !== 5'd0 || underflow !== 1'b0) begin
      $display("[TB] FAIL stream_pair2: got %0d,%0d level=%0d uf=%0b expected 200,-200 level=0 uf=0", out_i, out_q, level, underflow); miscompares++;
    end
    to_update();
    vectors++;
    if (out_i !== 16'sd0 || underflow !== 1'b1) begin
      $display("[TB] FAIL stream_drained: got out_i=%0d uf=%0b expected 0,1", out_i, underflow); miscompares++;
    end
  endtask

  task automatic test_fill_disabled();
    $display("[TB] fill with enable low");
    do_reset();
    enable = 1'b0;
    s_valid = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      s_i = 16'(k); s_q = 16'(-k);
      step(1);
    end
    s_i = 16'd17; s_q = 16'(-17);
    vectors++;
    if (s_ready !== 1'b0 || level !== 5'd16) begin
      $display("[TB] FAIL fill_full: got ready=%0b level=%0d expected 0,16", s_ready, level); miscompares++;
    end
    step(5);
    vectors++;
    if (level !== 5'd16 || out_i !== 16'sd0 || underflow !== 1'b0) begin
      $display("[TB] FAIL fill_hold: got level=%0d out_i=%0d uf=%0b expected 16,0,0", level, out_i, underflow); miscompares++;
    end
  endtask

  // Continues from the full FIFO left by test_fill_disabled.
  task automatic test_full_stream();
    int nxt;
    bit acc;
    $display("[TB] stream from full FIFO with sender active");
    nxt = 17;
    enable = 1'b1;
    for (int p = 1; p <= 3; p++) begin
      do begin
        acc = s_valid && s_ready;
        step(1);
        if (acc) begin nxt++; s_i = 16'(nxt); s_q = 16'(-nxt); end
      end while (cyc % 32 != 16);
      vectors++;
      if (out_i !== 16'(p) || out_q !== 16'(-p) || level !== 5'd15) begin
        $display("[TB] FAIL full_pop%0d: got %0d,%0d level=%0d expected %0d,%0d level=15", p, out_i, out_q, level, p, -p); miscompares++;
      end
      acc = s_valid && s_ready;
      step(1);
      if (acc) begin nxt++; s_i = 16'(nxt); s_q = 16'(-nxt); end
      vectors++;
      if (level !== 5'd16) begin
        $display("[TB] FAIL full_refill%0d: got level=%0d expected 16", p, level); miscompares++;
      end
    end
    s_valid = 1'b0;
    for (int k = 4; k <= 19; k++) begin
      to_update();
      vectors++;
      if (out_i !== 16'(k) || out_q !== 16'(-k)) begin
        $display("[TB] FAIL drain_order: got %0d,%0d expected %0d,%0d", out_i, out_q, k, -k); miscompares++;
      end
    end
    vectors++;
    if (level !== 5'd0 || underflow !== 1'b0) begin
      $display("[TB] FAIL drain_end: got level=%0d uf=%0b expected 0,0", level, underflow); miscompares++;
    end
  endtask

  task automatic test_push_on_pop_edge();
    $display("[TB] push into empty FIFO on the update edge");
    do_reset();
    enable = 1'b1;
    step(15);
    s_valid = 1'b1; s_i = 16'd55; s_q = 16'(-55);
    step(1);
    s_valid = 1'b0;
    vectors++;
    if (underflow !== 1'b1 || level !== 5'd1 || out_i !== 16'sd0) begin
      $display("[TB] FAIL edge_push: got uf=%0b level=%0d out_i=%0d expected 1,1,0", underflow, level, out_i); miscompares++;
    end
    to_update();
    vectors++;
    if (out_i !== 16'sd55 || out_q !== -16'sd55 || level !== 5'd0) begin
      $display("[TB] FAIL edge_next: got %0d,%0d level=%0d expected 55,-55 level=0", out_i, out_q, level); miscompares++;
    end
  endtask

  task automatic test_hold_on_underflow();
    $display("[TB] hold-last-pair instance");
    enable = 1'b0;
    do_reset();
    h_enable = 1'b1;
    h_s_valid = 1'b1; h_s_i = 16'd7; h_s_q = 16'(-7);
    step(1);
    h_s_valid = 1'b0;
    to_update();
    vectors++;
    if (h_out_i !== 16'sd7 || h_out_q !== -16'sd7 || h_underflow !== 1'b0) begin
      $display("[TB] FAIL hold_first: got %0d,%0d uf=%0b expected 7,-7 uf=0", h_out_i, h_out_q, h_underflow); miscompares++;
    end
    to_update();
    vectors++;
    if (h_out_i !== 16'sd7 || h_out_q !== -16'sd7 || h_underflow !== 1'b1 || h_out_strobe !== 1'b1) begin
      $display("[TB] FAIL hold_underflow: got %0d,%0d uf=%0b strobe=%0b expected 7,-7 uf=1 strobe=1", h_out_i, h_out_q, h_underflow, h_out_strobe); miscompares++;
    end
    h_enable = 1'b0;
  endtask

  task automatic test_clear_priority();
    $display("[TB] underflow clear priority");
    do_reset();
    enable = 1'b1;
    step(15);
    underflow_clr = 1'b1;
    step(1);
    underflow_clr = 1'b0;
    vectors++;
    if (underflow !== 1'b1) begin
      $display("[TB] FAIL clr_same_edge: got %0b expected 1", underflow); miscompares++;
    end
    step(4);
    underflow_clr = 1'b1;
    step(1);
    underflow_clr = 1'b0;
    vectors++;
    if (underflow !== 1'b0) begin
      $display("[TB] FAIL clr_plain: got %0b expected 0", underflow); miscompares++;
    end
  endtask

  task automatic test_mid_reset();
    $display("[TB] reset mid-stream");
    do_reset();
    enable = 1'b1;
    s_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      s_i = 16'(10 * k); s_q = 16'(-10 * k);
      step(1);
    end
    s_valid = 1'b0;
    to_update();
    vectors++;
    if (out_i !== 16'sd10 || level !== 5'd2) begin
      $display("[TB] FAIL mid_before: got out_i=%0d level=%0d expected 10,2", out_i, level); miscompares++;
    end
    step(31);
    reset = 1'b1;
    step(1);
    vectors++;
    if (level !== 5'd0 || out_i !== 16'sd0 || out_q !== 16'sd0 || s_ready !== 1'b1 || out_strobe !== 1'b0) begin
      $display("[TB] FAIL mid_reset: got level=%0d out=%0d,%0d ready=%0b strobe=%0b expected 0,0,0,1,0", level, out_i, out_q, s_ready, out_strobe); miscompares++;
    end
    reset = 1'b0;
    cyc = 0;
    step(16);
    vectors++;
    if (out_i !== 16'sd0 || underflow !== 1'b1 || level !== 5'd0) begin
      $display("[TB] FAIL mid_flushed: got out_i=%0d uf=%0b level=%0d expected 0,1,0", out_i, underflow, level); miscompares++;
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_idle_underflow();
    test_stream();
    test_fill_disabled();
    test_full_stream();
    test_push_on_pop_edge();
    test_hold_on_underflow();
    test_clear_priority();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
